calc_gravity_div: RTL and testbench



---
 rtl/calc_gravity_div.sv | 180 ++++++++++++++++++
 tb/tb_calc_gravity_div.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_gravity_div.sv
// calc_gravity_div: per-frame centre-of-gravity divider.
// Takes the accumulated pixel count and X/Y moment sums at end of frame,
// rejects blobs that are too small, and otherwise computes
// cx = sum_x/sum_s and cy = sum_y/sum_s as unsigned fixed-point values
// using a bit-serial restoring divider (one quotient bit per clock).
module calc_gravity_div #(
  parameter int AREA_WIDTH   = 20,
  parameter int MOMENT_WIDTH = 32,
  parameter int COORD_WIDTH  = 11,
  parameter int FRAC_BITS    = 4,
  localparam int Q           = COORD_WIDTH + FRAC_BITS
) (
  input  logic                    CCLK,
  input  logic                    RST_N,
  input  logic                    iSTART,
  input  logic [AREA_WIDTH-1:0]   iSUM_S,
  input  logic [MOMENT_WIDTH-1:0] iSUM_X,
  input  logic [MOMENT_WIDTH-1:0] iSUM_Y,
  input  logic [AREA_WIDTH-1:0]   iMIN_AREA,
  output logic                    oBUSY,
  output logic                    oVALID,
  output logic                    oFOUND,
  output logic [Q-1:0]            oCX,
  output logic [Q-1:0]            oCY,
  output logic [AREA_WIDTH-1:0]   oAREA,
  output logic                    oDROP
);

  localparam int CNT_W = $clog2(Q);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(Q - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIV_X,
    ST_DIV_Y,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [AREA_WIDTH-1:0]   s_lat;
  logic [AREA_WIDTH-1:0]   min_lat;
  logic [MOMENT_WIDTH-1:0] x_lat;
  logic [MOMENT_WIDTH-1:0] y_lat;
  logic [CNT_W-1:0]        cnt;
  logic [AREA_WIDTH:0]     rem;
  logic                    ovf;
  logic                    found;
  logic [Q-1:0]            qx;
  logic [Q-1:0]            qy;

  logic                    reject;
  logic                    first;
  logic [MOMENT_WIDTH-1:0] div_moment;
  logic [MOMENT_WIDTH-1:0] upper;
  logic                    ovf_now;
  logic                    ovf_cur;
  logic [Q-1:0]            div_low;
  logic                    div_bit;
  logic [AREA_WIDTH:0]     rem_cur;
  logic [AREA_WIDTH+1:0]   shifted;
  logic [AREA_WIDTH+1:0]   trial;
  logic                    trial_ok;
  logic                    q_bit;
  logic [AREA_WIDTH:0]     rem_nxt;

  assign oBUSY  = (state != ST_IDLE);
  assign reject = (s_lat == '0) || (s_lat < min_lat);

  // State register; reset aborts any division in flight.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: CHECK either rejects straight to DONE or runs both divisions.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (iSTART) state_nxt = ST_CHECK;
      ST_CHECK: state_nxt = reject ? ST_DONE : ST_DIV_X;
      ST_DIV_X: if (cnt == '0) state_nxt = ST_DIV_Y;
      ST_DIV_Y: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // One restoring-division step. The integer part of the quotient must fit in
  // COORD_WIDTH bits, so the dividend bits above Q only ever form the starting
  // partial remainder (moment >> COORD_WIDTH); if that is already >= S the
  // quotient would overflow and is forced to all ones instead.
  always_comb begin
    div_moment = (state == ST_DIV_Y) ? y_lat : x_lat;
    first      = (cnt == CNT_TOP);
    upper      = div_moment >> COORD_WIDTH;
    ovf_now    = (upper >= MOMENT_WIDTH'(s_lat));
    ovf_cur    = first ? ovf_now : ovf;
    div_low    = {div_moment[COORD_WIDTH-1:0], {FRAC_BITS{1'b0}}};
    div_bit    = div_low[cnt];
    rem_cur    = first ? upper[AREA_WIDTH:0] : rem;
    shifted    = {rem_cur, div_bit};
    trial      = shifted - {2'b00, s_lat};
    trial_ok   = ~trial[AREA_WIDTH+1];
    q_bit      = ovf_cur | trial_ok;
    rem_nxt    = trial_ok ? trial[AREA_WIDTH:0] : shifted[AREA_WIDTH:0];
  end

  // Operand latches, validity decision and the serial divider datapath.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      s_lat   <= '0;
      min_lat <= '0;
      x_lat   <= '0;
      y_lat   <= '0;
      cnt     <= '0;
      rem     <= '0;
      ovf     <= 1'b0;
      found   <= 1'b0;
      qx      <= '0;
      qy      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iSTART) begin
            s_lat   <= iSUM_S;
            min_lat <= iMIN_AREA;
            x_lat   <= iSUM_X;
            y_lat   <= iSUM_Y;
          end
        end
        ST_CHECK: begin
          found <= ~reject;
          cnt   <= CNT_TOP;
          rem   <= '0;
          ovf   <= 1'b0;
        end
        ST_DIV_X, ST_DIV_Y: begin
          if (state == ST_DIV_X) qx <= {qx[Q-2:0], q_bit};
          else                   qy <= {qy[Q-2:0], q_bit};
          if (cnt == '0) begin
            cnt <= CNT_TOP;
            rem <= '0;
            ovf <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
            rem <= rem_nxt;
            ovf <= ovf_cur;
          end
        end
        default: ;
      endcase
    end
  end

  // Registered result presented on leaving DONE; coordinates only move on a found blob.
  always_ff @(posedge CCLK or negedge RST_N) begin
    if (!RST_N) begin
      oVALID <= 1'b0;
      oFOUND <= 1'b0;
      oCX    <= '0;
      oCY    <= '0;
      oAREA  <= '0;
      oDROP  <= 1'b0;
    end else begin
      oVALID <= (state == ST_DONE);
      oDROP  <= iSTART && (state != ST_IDLE);
      if (state == ST_DONE) begin
        oFOUND <= found;
        oAREA  <= s_lat;
        if (found) begin
          oCX <= qx;
          oCY <= qy;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_gravity_div.sv
// tb_calc_gravity_div: directed and randomized frames against an arithmetic
// model of the centroid divider (plain integer division with saturation).
module tb_calc_gravity_div;

  localparam int AW   = 20;
  localparam int MW   = 32;
  localparam int CW   = 11;
  localparam int FB   = 4;
  localparam int Q    = CW + FB;
  localparam int LAT  = 2 * Q + 2;
  localparam logic [63:0] QMAX = 64'((1 << Q) - 1);

  logic          CCLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          iSTART = 1'b0;
  logic [AW-1:0] iSUM_S = '0;
  logic [MW-1:0] iSUM_X = '0;
  logic [MW-1:0] iSUM_Y = '0;
  logic [AW-1:0] iMIN_AREA = '0;
  logic          oBUSY;
  logic          oVALID;
  logic          oFOUND;
  logic [Q-1:0]  oCX;
  logic [Q-1:0]  oCY;
  logic [AW-1:0] oAREA;
  logic          oDROP;

  int checks = 0;
  int failures = 0;

  logic [Q-1:0]  model_cx = '0;
  logic [Q-1:0]  model_cy = '0;
  logic          model_found = 1'b0;
  logic [AW-1:0] model_area = '0;

  calc_gravity_div dut (
    .CCLK      (CCLK),
    .RST_N     (RST_N),
    .iSTART    (iSTART),
    .iSUM_S    (iSUM_S),
    .iSUM_X    (iSUM_X),
    .iSUM_Y    (iSUM_Y),
    .iMIN_AREA (iMIN_AREA),
    .oBUSY     (oBUSY),
    .oVALID    (oVALID),
    .oFOUND    (oFOUND),
    .oCX       (oCX),
    .oCY       (oCY),
    .oAREA     (oAREA),
    .oDROP     (oDROP)
  );

  always #5 CCLK = ~CCLK;

  task automatic step();
    @(posedge CCLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Centroid coordinate: (moment * 2^FB) / S, truncated, clipped to Q bits.
  function automatic logic [Q-1:0] refCoord(input logic [MW-1:0] m, input logic [AW-1:0] s);
    logic [63:0] q;
    q = (64'(m) << FB) / 64'(s);
    if (q > QMAX) return '1;
    return q[Q-1:0];
  endfunction

  task automatic checkAll(input string tag);
    checkOutput({tag, "_found"}, 64'(oFOUND), 64'(model_found));
    checkOutput({tag, "_cx"},    64'(oCX),    64'(model_cx));
    checkOutput({tag, "_cy"},    64'(oCY),    64'(model_cy));
    checkOutput({tag, "_area"},  64'(oAREA),  64'(model_area));
  endtask

  // Presents one frame; the operands are scrambled right after the sampling edge.
  task automatic applyStimulus(input logic [AW-1:0] s, input logic [MW-1:0] x,
                               input logic [MW-1:0] y, input logic [AW-1:0] mn);
    iSUM_S    = s;
    iSUM_X    = x;
    iSUM_Y    = y;
    iMIN_AREA = mn;
    iSTART    = 1'b1;
    step();
    iSTART    = 1'b0;
    iSUM_S    = AW'($urandom);
    iSUM_X    = $urandom;
    iSUM_Y    = $urandom;
    iMIN_AREA = AW'($urandom);
  endtask

  // Runs one frame up to its oVALID; pulseAt>0 injects an extra iSTART sampled on that edge.
  task automatic runFrame(input logic [AW-1:0] s, input logic [MW-1:0] x, input logic [MW-1:0] y,
                          input logic [AW-1:0] mn, input int pulseAt, input string tag);
    int    edges;
    int    busyCnt;
    int    expLat;
    logic  dropSeen;
    logic  accept;
    accept   = (s != '0) && (s >= mn);
    expLat   = accept ? LAT : 2;
    edges    = -1;
    busyCnt  = 0;
    dropSeen = 1'b0;
    applyStimulus(s, x, y, mn);
    if (oBUSY) busyCnt++;
    for (int i = 1; i <= 100; i++) begin
      if (i == pulseAt) begin
        iSTART    = 1'b1;
        iSUM_S    = AW'(1);
        iSUM_X    = 32'd7;
        iSUM_Y    = $urandom;
        iMIN_AREA = '0;
      end
      step();
      if (i == pulseAt) begin
        iSTART = 1'b0;
        checkOutput({tag, "_drop"}, 64'(oDROP), 64'd1);
      end else if (oDROP) begin
        dropSeen = 1'b1;
      end
      if (oVALID) begin
        edges = i;
        break;
      end
      if (oBUSY) busyCnt++;
    end
    model_found = accept;
    model_area  = s;
    if (accept) begin
      model_cx = refCoord(x, s);
      model_cy = refCoord(y, s);
    end
    checkOutput({tag, "_latency"}, 64'(edges),   64'(expLat));
    checkOutput({tag, "_busycyc"}, 64'(busyCnt), 64'(expLat));
    checkOutput({tag, "_busyend"}, 64'(oBUSY),   64'd0);
    checkOutput({tag, "_nodrop"},  64'(dropSeen), 64'd0);
    checkAll(tag);
  endtask

  // One idle cycle after a result: oVALID must drop and results must hold.
  task automatic settle(input string tag);
    step();
    checkOutput({tag, "_vpulse"}, 64'(oVALID), 64'd0);
    checkAll({tag, "_hold"});
  endtask

  initial begin
    int            mode;
    int unsigned   s_u;
    int unsigned   x_u;
    int unsigned   y_u;
    int unsigned   mn_u;
    int            validSeen;

    $display("[TB] start");
    step();
    step();
    checkOutput("rst_busy",  64'(oBUSY),  64'd0);
    checkOutput("rst_valid", 64'(oVALID), 64'd0);
    checkOutput("rst_drop",  64'(oDROP),  64'd0);
    checkAll("rst");
    RST_N = 1'b1;
    step();

    runFrame(AW'(4), 32'd402, 32'd202, AW'(1), 0, "basic");
    settle("basic");
    runFrame(AW'(0), 32'd999, 32'd999, AW'(0), 0, "zero_area");
    settle("zero_area");
    runFrame(AW'(5), 32'd500, 32'd300, AW'(6), 0, "below_min");
    settle("below_min");
    runFrame(AW'(5), 32'd500, 32'd300, AW'(5), 0, "eq_min");
    settle("eq_min");
    runFrame(AW'(3), 32'd10, 32'd0, AW'(1), 0, "trunc");
    settle("trunc");
    runFrame(AW'(1), 32'd5000, 32'd2047, AW'(0), 0, "saturate");
    settle("saturate");
    runFrame(AW'(307200), 32'hFFFF_FFFF, 32'd0, AW'(1), 0, "big");
    settle("big");

    $display("[TB] busy-drop and back-to-back frames");
    runFrame(AW'(4), 32'd402, 32'd202, AW'(1), 10, "drop10");
    runFrame(AW'(7), 32'd7000, 32'd1234, AW'(2), LAT, "b2b_done_drop");
    runFrame(AW'(2), 32'd10, 32'd10, AW'(9), 2, "b2b_rej_drop");
    settle("b2b_rej_drop");

    $display("[TB] reset during division");
    applyStimulus(AW'(4), 32'd402, 32'd202, AW'(1));
    repeat (12) step();
    RST_N = 1'b0;
    #1;
    model_cx    = '0;
    model_cy    = '0;
    model_found = 1'b0;
    model_area  = '0;
    checkOutput("mid_rst_busy",  64'(oBUSY),  64'd0);
    checkOutput("mid_rst_valid", 64'(oVALID), 64'd0);
    checkOutput("mid_rst_drop",  64'(oDROP),  64'd0);
    checkAll("mid_rst");
    step();
    step();
    RST_N = 1'b1;
    validSeen = 0;
    repeat (40) begin
      step();
      if (oVALID) validSeen++;
    end
    checkOutput("mid_rst_novalid", 64'(validSeen), 64'd0);
    runFrame(AW'(4), 32'd402, 32'd202, AW'(1), 0, "after_rst");
    settle("after_rst");

    $display("[TB] randomized frames");
    for (int n = 0; n < 30; n++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: begin
          s_u  = $urandom_range(1, 16);
          x_u  = $urandom_range(0, 70000);
          y_u  = $urandom_range(0, 70000);
          mn_u = $urandom_range(0, s_u);
        end
        1: begin
          s_u  = $urandom_range(1, 307200);
          x_u  = s_u * $urandom_range(0, 639) + $urandom_range(0, s_u - 1);
          y_u  = s_u * $urandom_range(0, 479) + $urandom_range(0, s_u - 1);
          mn_u = $urandom_range(0, s_u);
        end
        2: begin
          s_u  = $urandom_range(0, 100);
          x_u  = $urandom;
          y_u  = $urandom;
          mn_u = s_u + $urandom_range(1, 50);
        end
        default: begin
          s_u  = $urandom_range(1, (1 << AW) - 1);
          x_u  = $urandom;
          y_u  = $urandom;
          mn_u = $urandom_range(0, 1000);
        end
      endcase
      runFrame(AW'(s_u), x_u, y_u, AW'(mn_u), 0, $sformatf("rand%0d", n));
      if ($urandom_range(0, 1) == 1) settle($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
